// File: rtl/base_areskew.sv
// base_areskew: transmit-side advance/delay skewer.
// A beat enters with its advance and delayed fields together and leaves with
// the advance field in the transfer cycle and the delayed field one cycle later.
//
// Handshake semantics (both sides): a beat moves when valid and ready are both
// high in the same cycle. The sender keeps valid and data stable until the beat
// moves. i_r and o_v depend only on registered occupancy, so there is no
// combinational path from o_r to i_r and no same-cycle bypass from input to output.
module base_areskew #(
  parameter int del_width = 1,
  parameter int adv_width = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  input  logic [adv_width-1:0] i_d_adv,
  input  logic [del_width-1:0] i_d_del,
  output logic                 i_r,
  output logic                 o_v,
  output logic [adv_width-1:0] o_d_adv,
  input  logic                 o_r,
  output logic [del_width-1:0] o_d_del,
  output logic                 o_del_v
);

  // Two-entry FIFO storage, split per field.
  logic [adv_width-1:0] adv_mem_q [2];
  logic [adv_width-1:0] adv_mem_d [2];
  logic [del_width-1:0] del_mem_q [2];
  logic [del_width-1:0] del_mem_d [2];

  logic                 wptr_q, wptr_d;
  logic                 rptr_q, rptr_d;
  logic [1:0]           count_q, count_d;
  logic [del_width-1:0] o_d_del_q, o_d_del_d;
  logic                 o_del_v_q, o_del_v_d;

  logic push;
  logic pop;

  // Handshake outputs are driven purely from registered state.
  assign i_r     = (count_q != 2'd2);
  assign o_v     = (count_q != 2'd0);
  assign o_d_adv = adv_mem_q[rptr_q];
  assign o_d_del = o_d_del_q;
  assign o_del_v = o_del_v_q;

  // Next-state: write on accept, advance read and launch the delayed field on transfer.
  always_comb begin
    push      = i_v & i_r;
    pop       = o_v & o_r;
    adv_mem_d = adv_mem_q;
    del_mem_d = del_mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    o_d_del_d = o_d_del_q;
    o_del_v_d = pop;

    if (push) begin
      adv_mem_d[wptr_q] = i_d_adv;
      del_mem_d[wptr_q] = i_d_del;
      wptr_d            = ~wptr_q;
    end

    // The delayed field is captured from the head entry in its transfer cycle,
    // so it appears on o_d_del exactly one cycle after o_d_adv was taken.
    if (pop) begin
      rptr_d    = ~rptr_q;
      o_d_del_d = del_mem_q[rptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards stored beats and any pending delayed strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        adv_mem_q[i] <= '0;
        del_mem_q[i] <= '0;
      end
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
      o_d_del_q <= '0;
      o_del_v_q <= 1'b0;
    end else begin
      adv_mem_q <= adv_mem_d;
      del_mem_q <= del_mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      o_d_del_q <= o_d_del_d;
      o_del_v_q <= o_del_v_d;
    end
  end

endmodule
